// File: rtl/mem_port_arbiter.sv
// Shares one block-wide memory port between the I-cache (port 0) and D-cache (port 1); request seen in IDLE at t -> o_mem_cen at t+1 -> completion >= t+2.
// Backpressure: a requesting port stays stalled until its own completion cycle; memory stall is waited out in WAIT.
module mem_port_arbiter #(
    parameter int BIT_W      = 32,
    parameter int ADDR_W     = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_p0_cen,
    input  logic                 i_p0_wen,
    input  logic [ADDR_W-1:0]    i_p0_addr,
    input  logic [BIT_W*4-1:0]   i_p0_wdata,
    output logic [BIT_W*4-1:0]   o_p0_rdata,
    output logic                 o_p0_stall,
    input  logic                 i_p1_cen,
    input  logic                 i_p1_wen,
    input  logic [ADDR_W-1:0]    i_p1_addr,
    input  logic [BIT_W*4-1:0]   i_p1_wdata,
    output logic [BIT_W*4-1:0]   o_p1_rdata,
    output logic                 o_p1_stall,
    output logic                 o_mem_cen,
    output logic                 o_mem_wen,
    output logic [ADDR_W-1:0]    o_mem_addr,
    output logic [BIT_W*4-1:0]   o_mem_wdata,
    input  logic [BIT_W*4-1:0]   i_mem_rdata,
    input  logic                 i_mem_stall,
    output logic                 o_busy,
    output logic                 o_grant
);
    localparam int BLK_W = BIT_W * 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                grant_q, grant_d;
    logic                last_grant_q, last_grant_d;
    logic                mem_cen_q, mem_cen_d;
    logic                wen_q, wen_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BLK_W-1:0]    wdata_q, wdata_d;
    logic                sel_p1;
    logic                complete;

    always_comb begin
        if (i_p0_cen && i_p1_cen) begin
            sel_p1 = (FIXED_PRIO != 0) ? 1'b1 : ~last_grant_q;
        end else begin
            sel_p1 = i_p1_cen;
        end
    end

    assign complete = (state_q == WAIT) && !i_mem_stall;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        wen_d        = wen_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        mem_cen_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_p0_cen || i_p1_cen) begin
                    grant_d   = sel_p1;
                    wen_d     = sel_p1 ? i_p1_wen   : i_p0_wen;
                    addr_d    = sel_p1 ? i_p1_addr  : i_p0_addr;
                    wdata_d   = sel_p1 ? i_p1_wdata : i_p0_wdata;
                    mem_cen_d = 1'b1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (!i_mem_stall) begin
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            mem_cen_q    <= 1'b0;
            wen_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            mem_cen_q    <= mem_cen_d;
            wen_q        <= wen_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    // Only the granted port is released, and only in the cycle memory finishes.
    assign o_p0_stall  = i_p0_cen && !(complete && !grant_q);
    assign o_p1_stall  = i_p1_cen && !(complete && grant_q);
    assign o_p0_rdata  = i_mem_rdata;
    assign o_p1_rdata  = i_mem_rdata;
    assign o_mem_cen   = mem_cen_q;
    assign o_mem_wen   = wen_q;
    assign o_mem_addr  = addr_q;
    assign o_mem_wdata = wdata_q;
    assign o_busy      = (state_q != IDLE);
    assign o_grant     = grant_q;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 128-bit main-memory port between two block-level requesters: port 0 is the instruction cache, port 1 is the data cache.
- Each requester uses the same cen/wen/addr/wdata/stall handshake that a cache uses toward memory.
- The arbiter latches one request, issues it to memory, waits out i_mem_stall, and returns completion only to the granted port.
- Sits between the two Cache instances and the memory model.

Parameters:
- BIT_W, 32, word width; block width is BIT_W*4.
- ADDR_W, 32, address width.
- FIXED_PRIO, 0, 0 = round-robin between ports; 1 = port 1 always wins ties.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_p0_cen  in  1  port 0 request; held high until completion.
- i_p0_wen  in  1  port 0 write (1) / read (0).
- i_p0_addr  in  ADDR_W  port 0 block address.
- i_p0_wdata  in  BIT_W*4  port 0 write block.
- o_p0_rdata  out  BIT_W*4  read block for port 0.
- o_p0_stall  out  1  port 0 stall.
- i_p1_cen, i_p1_wen, i_p1_addr, i_p1_wdata, o_p1_rdata, o_p1_stall: same as port 0, for port 1.
- o_mem_cen  out  1  memory request strobe.
- o_mem_wen  out  1  memory write.
- o_mem_addr  out  ADDR_W  memory address.
- o_mem_wdata  out  BIT_W*4  memory write block.
- i_mem_rdata  in  BIT_W*4  memory read block.
- i_mem_stall  in  1  memory busy.
- o_busy  out  1  arbiter not IDLE.
- o_grant  out  1  currently or last granted port.

Behaviour:
- Reset (async, i_rst_n=0): state=IDLE; last_grant=1, so port 0 wins the first round-robin tie; latched wen/addr/wdata=0; o_mem_cen=0, o_mem_wen=0, o_mem_addr=0, o_mem_wdata=0, o_busy=0, o_grant=0. A reset mid-transaction abandons it; no completion is signalled.
- Memory contract: memory samples the request on the single cycle o_mem_cen=1. From the next cycle, i_mem_stall stays high until the cycle i_mem_rdata is valid or the write has committed. A memory with no wait states holds i_mem_stall low in that first cycle.
- States:
  - IDLE: if any cen is high, select a winner, latch its wen/addr/wdata and its port id into grant, and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE (one cycle): o_mem_cen=1; o_mem_wen/addr/wdata come from the latched values. Go to WAIT.
  - WAIT: o_mem_cen=0; latched outputs are held stable. If i_mem_stall=0, this is the completion cycle: go to IDLE and set last_grant=grant. Otherwise stay in WAIT.
- o_mem_wen/addr/wdata show the latched values in every state and change only when IDLE latches a new request.
- Arbitration:
  - Only one port requesting: that port wins.
  - Both requesting with FIXED_PRIO=0: the port that is not last_grant wins.
  - Both requesting with FIXED_PRIO=1: port 1 wins.
- Stall (combinational): o_pX_stall = i_pX_cen && !(state==WAIT && !i_mem_stall && grant==X). A non-granted requesting port stays stalled through the whole transaction. During reset, o_pX_stall = i_pX_cen.
- Read data: o_p0_rdata = o_p1_rdata = i_mem_rdata, combinational pass-through. It is meaningful only to the granted port in its completion cycle.
- Back-to-back requests: a requester that still holds cen in the cycle after completion, e.g. a cache moving from write-back to allocate, is treated as a new request in IDLE.
- Latency: request first seen high in IDLE at cycle t → o_mem_cen at t+1 → earliest completion at t+2. The arbiter adds 1 idle cycle between transactions.
- Request changes: a cen that drops before completion is a protocol violation. The arbiter still finishes the transaction and ignores the drop. addr/wdata changes after latching are ignored.
- No request is ever issued to memory while state != IDLE.

Test Plan:
- Single read, zero-wait memory: p0 cen=1, wen=0, addr=0x0000_0040; memory returns 0xAAAA…; stall low in first WAIT. Expected: o_mem_cen pulses 1 cycle with addr 0x40; o_p0_stall falls exactly 2 cycles after cen rises; o_p0_rdata=0xAAAA… in that cycle.
- Write with 3 stall cycles: p1 wen=1, addr=0x100, wdata=0x1234…; i_mem_stall high for 3 cycles. Expected: wen/addr/wdata stable through all of WAIT; o_p1_stall low only on the 4th WAIT cycle; p0 idle throughout.
- Simultaneous requests, FIXED_PRIO=0, right after reset: p0 addr 0x10, p1 addr 0x20 both held. Expected: p0 served first; p1 served next with 1 IDLE cycle between; repeated simultaneous pairs alternate p1, p0, p1.
- FIXED_PRIO=1, both requesting continuously: expected every grant is to p1 while p1 keeps requesting; p0 is granted only after p1 drops cen.
- Dirty-miss sequence on p1: write 0x200 followed immediately by read 0x300 with cen held across. Expected: two separate o_mem_cen pulses; p0 request arriving during the write is served between or after, per round-robin.
- Reset mid-WAIT: assert i_rst_n=0 with i_mem_stall=1. Expected: all outputs 0 asynchronously, o_busy=0, o_pX_stall = i_pX_cen; after release, a fresh request is issued normally.
